// File: rtl/conv_stim_driver.sv
// rtl/conv_stim_driver.sv - stimulus driver and golden checker for 3-tap convolution DUTs
// Optional feature macro: CONV_STIM_LFSR_EN (16-bit LFSR sample source instead of up-counter)
module conv_stim_driver #(
  parameter int DATA_W      = 4,
  parameter int TAPS        = 3,
  parameter int RESULT_W    = 10,
  parameter int NUM_VECTORS = 16,
  parameter int DUT_LATENCY = 2,
  parameter int ERR_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [TAPS*DATA_W-1:0] kernel_cfg,
  output logic [TAPS*DATA_W-1:0] kernel,
  output logic [DATA_W-1:0]      data,
  output logic                   data_valid,
  input  logic [RESULT_W-1:0]    result,
  output logic                   mismatch,
  output logic [ERR_W-1:0]       err_cnt,
  output logic                   busy,
  output logic                   done
);
  localparam int FULL_W = 2*DATA_W + $clog2(TAPS);
  localparam int VEC_W  = 16;
  localparam int DRN_W  = $clog2(DUT_LATENCY + 1) + 1;
  localparam int HIST_N = (TAPS > 1) ? TAPS - 1 : 1;
  localparam logic [VEC_W-1:0] LAST_VEC  = VEC_W'(NUM_VECTORS - 1);
  localparam logic [DRN_W-1:0] DRAIN_END = DRN_W'(DUT_LATENCY);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_DONE} state_t;
  state_t state, next_state;

  logic [VEC_W-1:0]    vec_cnt;
  logic [DRN_W-1:0]    drain_cnt;
  logic [DATA_W-1:0]   hist [HIST_N];
  logic [DATA_W-1:0]   h_new [TAPS];
  logic [DATA_W-1:0]   sample_next;
  logic [FULL_W-1:0]   acc;
  logic [RESULT_W-1:0] exp_next;
  logic [RESULT_W-1:0] exp_pipe [DUT_LATENCY];
  logic [DUT_LATENCY-1:0] vld_pipe;
  logic                start_run;
  logic                streaming;
  logic                cmp_fail;

  assign start_run = start && (state == S_IDLE || state == S_DONE);
  assign streaming = (state == S_STREAM);
  assign cmp_fail  = vld_pipe[DUT_LATENCY-1] && (result != exp_pipe[DUT_LATENCY-1]);

`ifdef CONV_STIM_LFSR_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  assign lfsr_next   = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign sample_next = lfsr_next[DATA_W-1:0];

  // LFSR reseeds on every LOAD and steps once per streamed vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else if (state == S_LOAD) lfsr <= 16'hACE1;
    else if (streaming) lfsr <= lfsr_next;
  end
`else
  logic [DATA_W-1:0] gen_cnt;
  assign sample_next = gen_cnt + 1'b1;

  // Up-counter generator: first vector of a run is 1, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gen_cnt <= '0;
    else if (start_run) gen_cnt <= '0;
    else if (streaming) gen_cnt <= sample_next;
  end
`endif

  // Golden convolution of the sample about to be launched against the loaded kernel
  always_comb begin
    h_new[0] = sample_next;
    for (int i = 1; i < TAPS; i++) h_new[i] = hist[i-1];
    acc = '0;
    for (int i = 0; i < TAPS; i++)
      acc = acc + FULL_W'(kernel[i*DATA_W +: DATA_W]) * FULL_W'(h_new[i]);
    exp_next = RESULT_W'(acc);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= next_state;
  end

  // FSM next state; DRAIN holds until the last compare has been registered
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_LOAD;
      S_LOAD:   next_state = S_STREAM;
      S_STREAM: if (vec_cnt == LAST_VEC) next_state = S_DRAIN;
      S_DRAIN:  if (drain_cnt == DRAIN_END) next_state = S_DONE;
      S_DONE:   if (start) next_state = S_LOAD;
      default:  next_state = S_IDLE;
    endcase
  end

  // Registered status flags track the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (next_state == S_LOAD) || (next_state == S_STREAM) || (next_state == S_DRAIN);
      done <= (next_state == S_DONE);
    end
  end

  // Vector and drain counters restart whenever their state is left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      vec_cnt   <= streaming ? vec_cnt + 1'b1 : '0;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  // Kernel load, sample launch and history shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kernel     <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      for (int i = 0; i < HIST_N; i++) hist[i] <= '0;
    end else begin
      data_valid <= streaming;
      if (state == S_LOAD) kernel <= kernel_cfg;
      if (start_run) begin
        for (int i = 0; i < HIST_N; i++) hist[i] <= '0;
      end else if (streaming) begin
        data    <= sample_next;
        hist[0] <= sample_next;
        for (int i = 1; i < HIST_N; i++) hist[i] <= hist[i-1];
      end
    end
  end

  // Expected-value alignment pipeline and saturating compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DUT_LATENCY; i++) exp_pipe[i] <= '0;
      vld_pipe <= '0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      exp_pipe[0] <= exp_next;
      vld_pipe[0] <= streaming;
      for (int i = 1; i < DUT_LATENCY; i++) begin
        exp_pipe[i] <= exp_pipe[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
      mismatch <= cmp_fail;
      if (start_run) err_cnt <= '0;
      else if (cmp_fail && err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule
